// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: D-stage redirect controls and ROM data in, fetch PC and
// IF/ID register contents out. The fetch unit uses the master side.
interface fetch_if;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic [31:0] D_jr_target;
  logic [31:0] F_ins;
  logic [31:0] F_pc;
  logic [31:0] D_pc;
  logic [31:0] D_ins;
  logic [31:0] D_pc8;
  logic        D_err;
  logic [31:0] fetch_cnt;

  modport master (
    input  stall, npc_sel, br_taken, D_imm16, D_imm26, D_jr_target, F_ins,
    output F_pc, D_pc, D_ins, D_pc8, D_err, fetch_cnt
  );

  modport slave (
    output stall, npc_sel, br_taken, D_imm16, D_imm26, D_jr_target, F_ins,
    input  F_pc, D_pc, D_ins, D_pc8, D_err, fetch_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage plus IF/ID pipeline register. Owns the PC, selects
// the next PC from D-stage redirects (one delay slot, never squashed) and
// flags fetches from outside the instruction ROM.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);

  localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  logic [31:0] F_pc_q, F_pc_d;
  logic [31:0] D_pc_q, D_pc_d;
  logic [31:0] D_ins_q, D_ins_d;
  logic        D_err_q, D_err_d;
  logic [31:0] cnt_q, cnt_d;

  logic        F_err;
  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] npc;

  // Illegal fetch: misaligned or outside the ROM window.
  assign F_err = (F_pc_q[1:0] != 2'b00) || (F_pc_q < PC_RESET) || (F_pc_q > PC_LAST);

  assign pc4       = F_pc_q + 32'd4;
  assign br_target = D_pc_q + 32'd4 + {{14{bus.D_imm16[15]}}, bus.D_imm16, 2'b00};

  // Next-PC select; jr target is used raw so a bad target surfaces as F_err.
  always_comb begin
    npc = pc4;
    unique case (npc_sel_e'(bus.npc_sel))
      NPC_SEQ: npc = pc4;
      NPC_BR:  npc = bus.br_taken ? br_target : pc4;
      NPC_J:   npc = {D_pc_q[31:28], bus.D_imm26, 2'b00};
      NPC_JR:  npc = bus.D_jr_target;
      default: npc = pc4;
    endcase
  end

  // Next state: stall freezes everything, otherwise advance F into D.
  always_comb begin
    F_pc_d  = F_pc_q;
    D_pc_d  = D_pc_q;
    D_ins_d = D_ins_q;
    D_err_d = D_err_q;
    cnt_d   = cnt_q;
    if (!bus.stall) begin
      F_pc_d  = npc;
      D_pc_d  = F_pc_q;
      D_ins_d = F_err ? 32'd0 : bus.F_ins;
      D_err_d = F_err;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  // PC and IF/ID register; reset loads a nop at the reset PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_pc_q  <= PC_RESET;
      D_pc_q  <= PC_RESET;
      D_ins_q <= 32'd0;
      D_err_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      F_pc_q  <= F_pc_d;
      D_pc_q  <= D_pc_d;
      D_ins_q <= D_ins_d;
      D_err_q <= D_err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.F_pc      = F_pc_q;
  assign bus.D_pc      = D_pc_q;
  assign bus.D_ins     = D_ins_q;
  assign bus.D_pc8     = D_pc_q + 32'd8;
  assign bus.D_err     = D_err_q;
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch/jump/jr redirects,
// stall priority, illegal-PC flagging and asynchronous reset.
module tb_fetch_unit;
  logic clk;
  logic reset;
  int   checks;
  int   passed;
  logic [31:0] exp_cnt;

  fetch_if bus();

  fetch_unit #(.PC_RESET(32'h0000_3000), .IM_WORDS(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Jump so that D holds addr and F holds addr+4.
  task automatic goto_pc(input logic [31:0] addr);
    bus.stall = 1'b0;
    bus.npc_sel = 2'd3;
    bus.D_jr_target = addr;
    step();
    bus.npc_sel = 2'd0;
    step();
    exp_cnt = exp_cnt + 32'd2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++; if (bus.F_pc !== 32'h3000) $display("FAIL rst_fpc got %h exp %h", bus.F_pc, 32'h3000); else passed++;
    checks++; if (bus.D_pc !== 32'h3000) $display("FAIL rst_dpc got %h exp %h", bus.D_pc, 32'h3000); else passed++;
    checks++; if (bus.D_ins !== 32'h0) $display("FAIL rst_dins got %h exp %h", bus.D_ins, 32'h0); else passed++;
    checks++; if (bus.D_err !== 1'b0) $display("FAIL rst_derr got %b exp 0", bus.D_err); else passed++;
    checks++; if (bus.fetch_cnt !== 32'h0) $display("FAIL rst_cnt got %0d exp 0", bus.fetch_cnt); else passed++;
    checks++; if (bus.D_pc8 !== 32'h3008) $display("FAIL rst_dpc8 got %h exp %h", bus.D_pc8, 32'h3008); else passed++;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_seq();
    bus.F_ins = 32'h3401_0006;
    step();
    exp_cnt = exp_cnt + 32'd1;
    checks++; if (bus.F_pc !== 32'h3004) $display("FAIL seq_fpc1 got %h exp %h", bus.F_pc, 32'h3004); else passed++;
    checks++; if (bus.D_pc !== 32'h3000) $display("FAIL seq_dpc1 got %h exp %h", bus.D_pc, 32'h3000); else passed++;
    checks++; if (bus.D_ins !== 32'h3401_0006) $display("FAIL seq_dins1 got %h exp %h", bus.D_ins, 32'h3401_0006); else passed++;
    checks++; if (bus.D_pc8 !== 32'h3008) $display("FAIL seq_dpc8 got %h exp %h", bus.D_pc8, 32'h3008); else passed++;
    checks++; if (bus.fetch_cnt !== 32'd1) $display("FAIL seq_cnt1 got %0d exp 1", bus.fetch_cnt); else passed++;
    step();
    checks++; if (bus.F_pc !== 32'h3008) $display("FAIL seq_fpc2 got %h exp %h", bus.F_pc, 32'h3008); else passed++;
    step();
    exp_cnt = exp_cnt + 32'd2;
    checks++; if (bus.F_pc !== 32'h300C) $display("FAIL seq_fpc3 got %h exp %h", bus.F_pc, 32'h300C); else passed++;
    checks++; if (bus.fetch_cnt !== 32'd3) $display("FAIL seq_cnt3 got %0d exp 3", bus.fetch_cnt); else passed++;
  endtask

  task automatic test_branch();
    goto_pc(32'h3128);
    checks++; if (bus.F_pc !== 32'h312C) $display("FAIL br_setup_fpc got %h exp %h", bus.F_pc, 32'h312C); else passed++;
    bus.npc_sel = 2'd1; bus.br_taken = 1'b1; bus.D_imm16 = 16'hFFD6;
    step();
    checks++; if (bus.F_pc !== 32'h3084) $display("FAIL br_taken_fpc got %h exp %h", bus.F_pc, 32'h3084); else passed++;
    checks++; if (bus.D_pc !== 32'h312C) $display("FAIL br_slot_dpc got %h exp %h", bus.D_pc, 32'h312C); else passed++;
    checks++; if (bus.D_ins !== 32'h3401_0006) $display("FAIL br_slot_dins got %h exp %h", bus.D_ins, 32'h3401_0006); else passed++;
    bus.npc_sel = 2'd0;
    step();
    checks++; if (bus.D_pc !== 32'h3084) $display("FAIL br_target_dpc got %h exp %h", bus.D_pc, 32'h3084); else passed++;
    exp_cnt = exp_cnt + 32'd2;
    // not taken
    goto_pc(32'h3128);
    bus.npc_sel = 2'd1; bus.br_taken = 1'b0;
    step();
    checks++; if (bus.F_pc !== 32'h3130) $display("FAIL br_nt_fpc got %h exp %h", bus.F_pc, 32'h3130); else passed++;
    exp_cnt = exp_cnt + 32'd1;
    // jal
    goto_pc(32'h3078);
    checks++; if (bus.D_pc8 !== 32'h3080) $display("FAIL jal_dpc8 got %h exp %h", bus.D_pc8, 32'h3080); else passed++;
    bus.npc_sel = 2'd2; bus.D_imm26 = 26'h000_0C24;
    step();
    checks++; if (bus.F_pc !== 32'h3090) $display("FAIL jal_fpc got %h exp %h", bus.F_pc, 32'h3090); else passed++;
    bus.npc_sel = 2'd0;
    exp_cnt = exp_cnt + 32'd1;
    checks++; if (bus.fetch_cnt !== exp_cnt) $display("FAIL br_cnt got %0d exp %0d", bus.fetch_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_stall();
    goto_pc(32'h3200);
    bus.stall = 1'b1; bus.npc_sel = 2'd3; bus.D_jr_target = 32'h3140;
    bus.F_ins = 32'h1234_5678;
    step();
    step();
    checks++; if (bus.F_pc !== 32'h3204) $display("FAIL stall_fpc got %h exp %h", bus.F_pc, 32'h3204); else passed++;
    checks++; if (bus.D_pc !== 32'h3200) $display("FAIL stall_dpc got %h exp %h", bus.D_pc, 32'h3200); else passed++;
    checks++; if (bus.D_ins !== 32'h3401_0006) $display("FAIL stall_dins got %h exp %h", bus.D_ins, 32'h3401_0006); else passed++;
    checks++; if (bus.fetch_cnt !== exp_cnt) $display("FAIL stall_cnt got %0d exp %0d", bus.fetch_cnt, exp_cnt); else passed++;
    bus.stall = 1'b0;
    step();
    exp_cnt = exp_cnt + 32'd1;
    checks++; if (bus.F_pc !== 32'h3140) $display("FAIL unstall_fpc got %h exp %h", bus.F_pc, 32'h3140); else passed++;
    checks++; if (bus.D_pc !== 32'h3204) $display("FAIL unstall_dpc got %h exp %h", bus.D_pc, 32'h3204); else passed++;
    checks++; if (bus.D_ins !== 32'h1234_5678) $display("FAIL unstall_dins got %h exp %h", bus.D_ins, 32'h1234_5678); else passed++;
    bus.npc_sel = 2'd0;
  endtask

  task automatic test_err();
    logic [31:0] tgt [4];
    logic        err [4];
    tgt[0] = 32'h3002; err[0] = 1'b1;
    tgt[1] = 32'h7000; err[1] = 1'b1;
    tgt[2] = 32'h6FFC; err[2] = 1'b0;
    tgt[3] = 32'h2FFC; err[3] = 1'b1;
    bus.F_ins = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      goto_pc(tgt[i]);
      checks++; if (bus.D_pc !== tgt[i]) $display("FAIL err_dpc[%0d] got %h exp %h", i, bus.D_pc, tgt[i]); else passed++;
      checks++; if (bus.D_err !== err[i]) $display("FAIL err_derr[%0d] got %b exp %b", i, bus.D_err, err[i]); else passed++;
      checks++; if (bus.D_ins !== (err[i] ? 32'h0 : 32'hDEAD_BEEF)) $display("FAIL err_dins[%0d] got %h exp %h", i, bus.D_ins, err[i] ? 32'h0 : 32'hDEAD_BEEF); else passed++;
    end
    checks++; if (bus.fetch_cnt !== exp_cnt) $display("FAIL err_cnt got %0d exp %0d", bus.fetch_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_async_reset();
    goto_pc(32'h3400);
    bus.stall = 1'b1; bus.npc_sel = 2'd3; bus.D_jr_target = 32'h3500;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.F_pc !== 32'h3000) $display("FAIL arst_fpc got %h exp %h", bus.F_pc, 32'h3000); else passed++;
    checks++; if (bus.D_ins !== 32'h0) $display("FAIL arst_dins got %h exp %h", bus.D_ins, 32'h0); else passed++;
    checks++; if (bus.fetch_cnt !== 32'h0) $display("FAIL arst_cnt got %0d exp 0", bus.fetch_cnt); else passed++;
    checks++; if (bus.D_err !== 1'b0) $display("FAIL arst_derr got %b exp 0", bus.D_err); else passed++;
    #2;
    reset = 1'b0;
    bus.stall = 1'b0; bus.npc_sel = 2'd0;
    step();
    checks++; if (bus.F_pc !== 32'h3004) $display("FAIL arst_resume_fpc got %h exp %h", bus.F_pc, 32'h3004); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; exp_cnt = 32'd0;
    reset = 1'b1;
    bus.stall = 1'b0; bus.npc_sel = 2'd0; bus.br_taken = 1'b0;
    bus.D_imm16 = 16'h0; bus.D_imm26 = 26'h0; bus.D_jr_target = 32'h0;
    bus.F_ins = 32'h0;
    test_reset();
    test_seq();
    test_branch();
    test_stall();
    test_err();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage (F) and IF/ID pipeline register of the P5 five-stage MIPS pipeline.
- Owns the PC and drives it to the instruction ROM (word array, base 0x0000_3000, 4096 words), which returns the instruction combinationally.
- Latches the PC/instruction pair into the D stage.
- Computes the next PC from redirect requests issued by the D stage. Architecture has one branch delay slot, so there is no flush.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset; base of instruction space.
- IM_WORDS, 4096, instruction ROM depth in words; legal F_pc range is [PC_RESET, PC_RESET+4*IM_WORDS-4].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds the PC and the IF/ID register.
- npc_sel  in  2  next-PC source: 0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr.
- br_taken  in  1  branch comparison result from D; used only when npc_sel=1.
- D_imm16  in  16  branch offset field of the D instruction.
- D_imm26  in  26  jump index field of the D instruction.
- D_jr_target  in  32  forwarded rs value for jr.
- F_ins  in  32  instruction returned by the ROM for F_pc.
- F_pc  out  32  current fetch PC, to ROM.
- D_pc  out  32  PC of the instruction held in D.
- D_ins  out  32  instruction held in D.
- D_pc8  out  32  D_pc+8; link value for jal.
- D_err  out  1  D instruction was fetched from an illegal PC.
- fetch_cnt  out  32  count of instructions advanced into D.

Behaviour:
- Reset (async, immediate):
  - F_pc=PC_RESET.
  - D_pc=PC_RESET, D_ins=0 (nop), D_err=0, fetch_cnt=0.
  - D_pc8 therefore reads PC_RESET+8.
- F_err is an internal combinational flag, set when:
  - F_pc[1:0]!=0, or
  - F_pc<PC_RESET, or
  - F_pc>PC_RESET+4*IM_WORDS-4.
- Next PC (npc), combinational, all arithmetic modulo 2^32:
  - npc_sel=0: F_pc+4.
  - npc_sel=1, br_taken=1: D_pc+4+(sext(D_imm16)<<2).
  - npc_sel=1, br_taken=0: F_pc+4.
  - npc_sel=2: {D_pc[31:28], D_imm26, 2'b00}.
  - npc_sel=3: D_jr_target, taken as-is with no alignment correction. A misaligned target is caught by F_err on the next fetch.
- Each rising edge with stall=0:
  - F_pc<=npc.
  - D_pc<=F_pc.
  - D_ins<=F_err ? 0 : F_ins.
  - D_err<=F_err.
  - fetch_cnt<=fetch_cnt+1, wrapping at 2^32.
- Each rising edge with stall=1:
  - F_pc, D_pc, D_ins, D_err and fetch_cnt all hold.
  - npc_sel and br_taken are ignored; stall has priority over redirect.
- Delay slot: when a D redirect is taken, the instruction in F at that edge still advances into D. It is never squashed.
- Latency:
  - Redirect decided in D takes effect on F_pc one edge later.
  - The target instruction reaches D two edges after the branch was in D.
- Reset mid-operation overrides stall and redirect immediately and asynchronously.
- D_pc8 = D_pc+8, combinational.

Test Plan:
- Reset then 3 edges, stall=0, npc_sel=0, F_ins=0x34010006 at 0x3000 -> F_pc sequence 0x3000, 0x3004, 0x3008, 0x300C. After edge 1: D_pc=0x3000, D_ins=0x34010006, D_pc8=0x3008, fetch_cnt=1.
- Branch taken: D_pc=0x3128, npc_sel=1, br_taken=1, D_imm16=0xFFD6, F_pc=0x312C -> edge 1: F_pc=0x3084 and D holds the delay slot (D_pc=0x312C). Edge 2: D_pc=0x3084.
- Branch not taken (same stimulus, br_taken=0) -> F_pc=0x3130. jal with D_pc=0x3078, D_imm26=0x0000C24 -> F_pc=0x3090, D_pc8=0x3080.
- stall=1 for 2 edges while npc_sel=3, D_jr_target=0x3140 -> F_pc, D_pc, D_ins and fetch_cnt are unchanged. The jr takes effect on the first edge after stall drops.
- jr to 0x3002, then to 0x7000 -> after each reaches D: D_err=1, D_ins=0. PC_RESET+4*IM_WORDS-4=0x6FFC fetches with D_err=0.
- Assert reset asynchronously mid-cycle between edges -> F_pc=0x3000, D_ins=0 and fetch_cnt=0 before the next clock edge.
